shift_reg_frame_ctrl: RTL and testbench

SHIFT_REG_FRAME_CTRL -- requirements
Module: shift_reg_frame_ctrl

---
 rtl/shift_reg_frame_ctrl_pkg.sv | 19 +
 rtl/shift_reg_frame_ctrl_sym_counter.sv | 27 ++
 rtl/shift_reg_frame_ctrl.sv | 122 ++++++++++++
 tb/tb_shift_reg_frame_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_frame_ctrl_pkg.sv
// Shared definitions for the shift-register frame controller: state encoding
// and counter width helper.
`timescale 1ns/1ps
package shift_reg_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_FULL  = 3'd4
  } frame_state_t;

  // Counter must be able to hold the full-frame value SHIFT_LEN itself.
  function automatic int cntWidth(input int shiftLen);
    return $clog2(shiftLen + 1);
  endfunction

endpackage

// File: rtl/shift_reg_frame_ctrl_sym_counter.sv
// Symbol counter with synchronous clear (priority) and increment enable.
`timescale 1ns/1ps
module sym_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/shift_reg_frame_ctrl.sv
// Frame controller feeding a downstream shift_reg: clears it, streams one
// frame of SHIFT_LEN symbols into it, then holds until the frame is consumed.
`timescale 1ns/1ps
module shift_reg_frame_ctrl
  import shift_reg_frame_ctrl_pkg::*;
#(
  parameter int SHIFT_LEN = 16,
  parameter int BIT_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               in_ctr_Arst_n,
  input  logic                               in_start,
  input  logic                               in_abort,
  input  logic                               in_valid,
  input  logic [BIT_WIDTH-1:0]               in_data,
  output logic                               out_ready,
  output logic                               out_Srst,
  output logic                               out_en,
  output logic [BIT_WIDTH-1:0]               out_value,
  output logic [$clog2(SHIFT_LEN+1)-1:0]     out_cnt,
  output logic                               out_frame_full,
  input  logic                               in_frame_ack
);

  localparam int CNT_W = cntWidth(SHIFT_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_LEN - 1);

  frame_state_t         r_state;
  frame_state_t         w_nextState;
  logic                 r_loadFlag;
  logic                 w_nextLoadFlag;
  logic                 w_accept;
  logic                 r_srst;
  logic                 r_en;
  logic [BIT_WIDTH-1:0] r_value;
  logic                 r_full;
  logic [CNT_W-1:0]     w_cnt;

  assign out_ready = (r_state == ST_LOAD);

  // Abort overrides everything, including an accept in the same cycle.
  always_comb begin
    w_nextState    = r_state;
    w_nextLoadFlag = r_loadFlag;
    w_accept       = in_valid && out_ready && !in_abort;
    if (in_abort) begin
      w_nextState    = ST_CLEAR;
      w_nextLoadFlag = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_start) begin
            w_nextState    = ST_CLEAR;
            w_nextLoadFlag = 1'b1;
          end
        end
        ST_CLEAR: w_nextState = r_loadFlag ? ST_LOAD : ST_IDLE;
        ST_LOAD: begin
          if (w_accept && (w_cnt == LAST_CNT)) begin
            w_nextState = ST_FLUSH;
          end
        end
        ST_FLUSH: w_nextState = ST_FULL;
        ST_FULL: begin
          if (in_frame_ack) begin
            if (in_start) begin
              w_nextState    = ST_CLEAR;
              w_nextLoadFlag = 1'b1;
            end else begin
              w_nextState = ST_IDLE;
            end
          end
        end
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      r_state    <= ST_IDLE;
      r_loadFlag <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_loadFlag <= w_nextLoadFlag;
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state they belong to.
  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      r_srst  <= 1'b0;
      r_en    <= 1'b0;
      r_value <= '0;
      r_full  <= 1'b0;
    end else begin
      r_srst <= (w_nextState == ST_CLEAR);
      r_en   <= w_accept;
      r_full <= (w_nextState == ST_FULL);
      if (w_accept) begin
        r_value <= in_data;
      end
    end
  end

  sym_counter #(
    .WIDTH(CNT_W)
  ) u_symCounter (
    .clk    (clk),
    .i_rst_n(in_ctr_Arst_n),
    .i_clr  (w_nextState == ST_CLEAR),
    .i_inc  (w_accept),
    .o_cnt  (w_cnt)
  );

  assign out_Srst       = r_srst;
  assign out_en         = r_en;
  assign out_value      = r_value;
  assign out_cnt        = w_cnt;
  assign out_frame_full = r_full;

endmodule

// File: tb/tb_shift_reg_frame_ctrl.sv
// Directed + randomized bench for shift_reg_frame_ctrl against a cycle-level
// behavioural model and a downstream shift register fed from the DUT outputs.
`timescale 1ns/1ps
module tb_shift_reg_frame_ctrl;

  localparam int SHIFT_LEN = 16;
  localparam int BIT_WIDTH = 4;
  localparam int CNT_W     = $clog2(SHIFT_LEN + 1);

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_LOAD  = 2;
  localparam int P_FLUSH = 3;
  localparam int P_FULL  = 4;

  logic                 clk = 1'b0;
  logic                 in_ctr_Arst_n = 1'b0;
  logic                 in_start = 1'b0;
  logic                 in_abort = 1'b0;
  logic                 in_valid = 1'b0;
  logic [BIT_WIDTH-1:0] in_data = '0;
  logic                 in_frame_ack = 1'b0;
  logic                 out_ready;
  logic                 out_Srst;
  logic                 out_en;
  logic [BIT_WIDTH-1:0] out_value;
  logic [CNT_W-1:0]     out_cnt;
  logic                 out_frame_full;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model state
  int                   mPhase = P_IDLE;
  bit                   mLoad = 1'b0;
  int                   mCnt = 0;
  logic                 expSrst = 1'b0;
  logic                 expEn = 1'b0;
  logic [BIT_WIDTH-1:0] expValue = '0;
  logic [BIT_WIDTH-1:0] frameQ [$];

  logic [SHIFT_LEN*BIT_WIDTH-1:0] shReg = '0;

  shift_reg_frame_ctrl #(
    .SHIFT_LEN(SHIFT_LEN),
    .BIT_WIDTH(BIT_WIDTH)
  ) dut (
    .clk           (clk),
    .in_ctr_Arst_n (in_ctr_Arst_n),
    .in_start      (in_start),
    .in_abort      (in_abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_ready     (out_ready),
    .out_Srst      (out_Srst),
    .out_en        (out_en),
    .out_value     (out_value),
    .out_cnt       (out_cnt),
    .out_frame_full(out_frame_full),
    .in_frame_ack  (in_frame_ack)
  );

  always #5 clk = ~clk;

  // Downstream forward shift register driven purely by the DUT control outputs
  always @(posedge clk) begin
    if (out_Srst) shReg <= '0;
    else if (out_en) shReg <= {shReg[SHIFT_LEN*BIT_WIDTH-BIT_WIDTH-1:0], out_value};
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkFrame(input string tag);
    logic [63:0] exp = '0;
    foreach (frameQ[i]) exp = (exp << BIT_WIDTH) | 64'(frameQ[i]);
    checkVal(tag, 64'(shReg), exp);
  endtask

  task automatic checkOutput();
    checkVal("out_Srst", 64'(out_Srst), 64'(expSrst));
    checkVal("out_en", 64'(out_en), 64'(expEn));
    checkVal("out_value", 64'(out_value), 64'(expValue));
    checkVal("out_cnt", 64'(out_cnt), 64'(mCnt));
    checkVal("out_frame_full", 64'(out_frame_full), 64'(mPhase == P_FULL));
    checkVal("out_ready", 64'(out_ready), 64'(mPhase == P_LOAD));
    if (mPhase == P_FULL) checkFrame("frame_contents");
  endtask

  task automatic enterClear(input bit loadAfter);
    mPhase  = P_CLEAR;
    mLoad   = loadAfter;
    mCnt    = 0;
    expSrst = 1'b1;
    frameQ.delete();
  endtask

  // One clock: drive inputs at the falling edge, advance the model, check after the rising edge.
  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic [BIT_WIDTH-1:0] d, input logic k);
    bit acc;
    @(negedge clk);
    in_start = s; in_abort = a; in_valid = v; in_data = d; in_frame_ack = k;
    expSrst = 1'b0;
    expEn   = 1'b0;
    acc     = v && (mPhase == P_LOAD) && !a;
    if (a) begin
      enterClear(1'b0);
    end else begin
      case (mPhase)
        P_IDLE:  if (s) enterClear(1'b1);
        P_CLEAR: mPhase = mLoad ? P_LOAD : P_IDLE;
        P_LOAD: begin
          if (acc) begin
            expEn    = 1'b1;
            expValue = d;
            mCnt++;
            frameQ.push_back(d);
            if (mCnt == SHIFT_LEN) mPhase = P_FLUSH;
          end
        end
        P_FLUSH: mPhase = P_FULL;
        default: begin
          if (k && s) enterClear(1'b1);
          else if (k) mPhase = P_IDLE;
        end
      endcase
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // mode 0: symbol = index, 1: constant 0x5, else random
  task automatic loadSymbols(input int target, input int mode, input bit toggle, input bit noise);
    int guard = 0;
    logic v = 1'b1;
    logic [BIT_WIDTH-1:0] d;
    while (mCnt < target && guard < 100) begin
      case (mode)
        0:       d = BIT_WIDTH'(mCnt);
        1:       d = 4'h5;
        default: d = BIT_WIDTH'($urandom_range(0, 15));
      endcase
      applyStimulus(noise, 1'b0, v, d, noise);
      if (toggle) v = ~v;
      guard++;
    end
    checkVal("load_budget", 64'(guard < 100), 64'(1));
  endtask

  task automatic asyncReset();
    #2;
    in_ctr_Arst_n = 1'b0;
    mPhase = P_IDLE; mLoad = 1'b0; mCnt = 0;
    expSrst = 1'b0; expEn = 1'b0; expValue = '0;
    #1;
    checkOutput();
    @(negedge clk);
    in_ctr_Arst_n = 1'b1;
  endtask

  initial begin
    int startTime;
    // Power-on reset
    #3;
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    in_ctr_Arst_n = 1'b1;
    idleStep();

    // Frame of 0x0..0xF back to back
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    loadSymbols(SHIFT_LEN, 0, 1'b0, 1'b0);
    idleStep();
    checkVal("pattern_0123", 64'(shReg), 64'h0123456789ABCDEF);
    idleStep();

    // Back-to-back frame of 0x5 via ack+start in FULL
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    loadSymbols(SHIFT_LEN, 1, 1'b0, 1'b0);
    idleStep();
    checkVal("pattern_5555", 64'(shReg), 64'h5555555555555555);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Valid toggling: 16 symbols in 31 LOAD cycles
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    idleStep();
    startTime = int'($time);
    loadSymbols(SHIFT_LEN, 2, 1'b1, 1'b0);
    checkVal("toggle_cycles", 64'((int'($time) - startTime) / 10), 64'(31));
    idleStep();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Start/ack noise during LOAD, then abort coinciding with an accept at count 7
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    loadSymbols(7, 2, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hA, 1'b0);
    idleStep();
    idleStep();

    // Asynchronous reset mid-frame at count 9, then clean restart
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    loadSymbols(9, 2, 1'b0, 1'b0);
    asyncReset();
    idleStep();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    loadSymbols(SHIFT_LEN, 2, 1'b0, 1'b0);
    idleStep();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom_range(0, 7) == 0),
                    logic'($urandom_range(0, 40) == 0),
                    logic'($urandom_range(0, 1)),
                    BIT_WIDTH'($urandom_range(0, 15)),
                    logic'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
